// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the programmable clock-enable divider.
//   state_e : controller states (IDLE, RUN, PEND)
//   DIV_MIN : smallest legal divisor
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Period counter, wrap detect and registered tick / clk_o decode.
// The outputs are decoded from the values the counter and divisor take on the
// coming edge, so they are registered yet line up with the count they describe.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_run       : controller is currently in RUN or PEND
//   i_run_nxt   : controller will be in RUN or PEND after this edge
//   i_div       : divisor in effect this cycle
//   i_div_nxt   : divisor in effect after this edge
//   o_wrap      : this cycle is the last of the period (boundary)
//   o_tick      : registered strobe, high while the count is 0
//   o_clk_o     : registered level, high while count < floor(div/2)
// -----------------------------------------------------------------------------
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_run_nxt,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_div_nxt,
  output logic             o_wrap,
  output logic             o_tick,
  output logic             o_clk_o
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             r_clk_o;

  assign o_wrap = i_run && (r_cnt == (i_div - CNT_W'(1)));

  // A fresh start, a wrap and a stop all land the counter on 0.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_cnt_nxt = '0;
    if (i_run_nxt && i_run && !o_wrap) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_clk_o <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_tick  <= i_run_nxt && (w_cnt_nxt == '0);
      r_clk_o <= i_run_nxt && (w_cnt_nxt < (i_div_nxt >> 1));
    end
  end

  assign o_tick  = r_tick;
  assign o_clk_o = r_clk_o;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time programmable clock-enable divider. Divisor updates arrive over a
// valid/ready handshake and take effect only on a period boundary.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run request; dropping it stops at the end of the period
//   cfg_valid  : divisor update request
//   cfg_div    : requested divisor (legal when >= DIV_MIN)
//   cfg_ready  : update can be accepted (low while an update is pending)
//   cfg_err    : one-cycle pulse after an illegal request was consumed
//   tick       : one-cycle strobe at the start of every period
//   clk_o      : high for floor(cur_div/2) cycles of each period
//   running    : controller in RUN or PEND
//   cur_div    : divisor currently in effect
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_o,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_cfg_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_take;
  logic             w_idle;
  logic             w_bound;
  logic             w_run_nxt;
  logic [CNT_W-1:0] w_div_nxt;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = cfg_valid && cfg_ready;
  assign w_legal  = (cfg_div >= CNT_W'(DIV_MIN));
  assign w_take   = w_accept && w_legal;

  // Only a boundary can end a period, so outside IDLE we keep running until then.
  assign w_run_nxt = (w_idle || w_bound) ? en : 1'b1;

  // Divisor seen by the next cycle. A legal write that lands on a stopping
  // boundary in RUN is applied directly, as it would be in IDLE.
  always_comb begin
    w_div_nxt = r_cur_div;
    if (w_idle && w_take) begin
      w_div_nxt = cfg_div;
    end else if (w_bound && (r_state == PEND)) begin
      w_div_nxt = r_pend_div;
    end else if (w_bound && (r_state == RUN) && w_take && !en) begin
      w_div_nxt = cfg_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur_div  <= CNT_W'(DIV_RESET);
      // NOTE: the pending register is reset too, so a value staged before reset
      // can never leak into the first period afterwards.
      r_pend_div <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cur_div <= w_div_nxt;
      r_cfg_err <= w_accept && !w_legal;
      case (r_state)
        IDLE: begin
          if (en) r_state <= RUN;
        end
        RUN: begin
          if (w_bound && !en) begin
            r_state <= IDLE;
          end else if (w_take) begin
            r_pend_div <= cfg_div;
            r_state    <= PEND;
          end
        end
        PEND: begin
          if (w_bound) begin
            r_pend_div <= '0;
            r_state    <= en ? RUN : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (!w_idle),
    .i_run_nxt (w_run_nxt),
    .i_div     (r_cur_div),
    .i_div_nxt (w_div_nxt),
    .o_wrap    (w_bound),
    .o_tick    (tick),
    .o_clk_o   (clk_o)
  );

  assign cfg_ready = (r_state != PEND);
  assign cfg_err   = r_cfg_err;
  assign running   = !w_idle;
  assign cur_div   = r_cur_div;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       tick;
  logic       clk_o;
  logic       running;
  logic [7:0] cur_div;

  int checks = 0;
  int failures = 0;

  clk_div_ctrl #(.CNT_W(8), .DIV_RESET(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_o     (clk_o),
    .running   (running),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic e_tick, input logic e_clko,
                           input logic e_run, input logic e_rdy, input logic e_err,
                           input logic [7:0] e_div);
    check({name, ".tick"},      tick,      e_tick);
    check({name, ".clk_o"},     clk_o,     e_clko);
    check({name, ".running"},   running,   e_run);
    check({name, ".cfg_ready"}, cfg_ready, e_rdy);
    check({name, ".cfg_err"},   cfg_err,   e_err);
    check({name, ".cur_div"},   cur_div,   e_div);
  endtask

  task automatic drive(input logic e, input logic v, input logic [7:0] d);
    en = e; cfg_valid = v; cfg_div = d;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst_n = 1'b0;
    cycle();
    #2 rst_n = 1'b1;
    cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each period is a queue of (tick, clk_o) samples built from
  // the divisor; the queue running dry marks the period boundary.
  // ---------------------------------------------------------------------------
  logic [1:0] m_q[$];
  bit  m_run, m_pend_v, m_err, m_tick, m_clko;
  int  m_cur, m_pend;

  function automatic void m_reset();
    m_q.delete();
    m_run = 0; m_pend_v = 0; m_err = 0; m_tick = 0; m_clko = 0;
    m_cur = 3; m_pend = 0;
  endfunction

  function automatic void m_pop();
    logic [1:0] s;
    s = m_q.pop_front();
    m_tick = s[1];
    m_clko = s[0];
  endfunction

  function automatic void m_start();
    m_q.delete();
    for (int i = 0; i < m_cur; i++) m_q.push_back({(i == 0), (i < m_cur / 2)});
    m_run = 1;
    m_pop();
  endfunction

  function automatic void m_stop();
    m_run = 0; m_tick = 0; m_clko = 0;
  endfunction

  function automatic void m_step(input bit e, input bit v, input int d);
    bit acc, legal;
    acc   = v && !m_pend_v;
    legal = (d >= 2);
    if (!m_run) begin
      if (acc && legal) m_cur = d;
      if (e) m_start(); else m_stop();
    end else if (m_q.size() == 0) begin
      if (m_pend_v) begin
        m_cur = m_pend; m_pend_v = 0;
      end else if (acc && legal) begin
        if (e) begin m_pend = d; m_pend_v = 1; end
        else m_cur = d;
      end
      if (e) m_start(); else m_stop();
    end else begin
      if (acc && legal) begin m_pend = d; m_pend_v = 1; end
      m_pop();
    end
    m_err = acc && !legal;
  endfunction

  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       tick;
    logic       clko;
    logic       run;
    logic       rdy;
    logic       err;
    logic [7:0] cd;
  } vec_t;

  vec_t vec[14];

  initial begin
    // Start with N=3, retarget to 5 at cnt=1, then two illegal writes.
    vec[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3};
    vec[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    vec[2]  = '{1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
    vec[3]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[7]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[9]  = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5};
    vec[10] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5};
    vec[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[12] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};
    vec[13] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5};

    // Reset state.
    do_reset();
    check_all("reset", 0, 0, 0, 1, 0, 8'd3);

    // Table-driven sequence.
    for (int i = 0; i < 14; i++) begin
      drive(vec[i].en, vec[i].v, vec[i].d);
      cycle();
      check_all($sformatf("vec%0d", i), vec[i].tick, vec[i].clko, vec[i].run,
                vec[i].rdy, vec[i].err, vec[i].cd);
    end

    // Stop with N=4: drop en at cnt=0, three more cycles, then idle; restart.
    do_reset();
    drive(0, 1, 8'd4); cycle();
    check_all("stop.load", 0, 0, 0, 1, 0, 8'd4);
    drive(1, 0, 0); cycle();
    check_all("stop.c0", 1, 1, 1, 1, 0, 8'd4);
    drive(0, 0, 0); cycle();
    check_all("stop.c1", 0, 1, 1, 1, 0, 8'd4);
    cycle();
    check_all("stop.c2", 0, 0, 1, 1, 0, 8'd4);
    cycle();
    check_all("stop.c3", 0, 0, 1, 1, 0, 8'd4);
    cycle();
    check_all("stop.idle0", 0, 0, 0, 1, 0, 8'd4);
    cycle();
    check_all("stop.idle1", 0, 0, 0, 1, 0, 8'd4);
    drive(1, 0, 0); cycle();
    check_all("stop.restart", 1, 1, 1, 1, 0, 8'd4);

    // Reset while in PEND at cnt=2; pending value must be discarded.
    do_reset();
    drive(1, 0, 0); cycle();
    check_all("pend.c0", 1, 1, 1, 1, 0, 8'd3);
    drive(1, 1, 8'd6); cycle();
    check_all("pend.c1", 0, 0, 1, 0, 0, 8'd3);
    drive(1, 0, 0); cycle();
    check_all("pend.c2", 0, 0, 1, 0, 0, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    check("pend.rst.tick", tick, 0);
    check("pend.rst.clk_o", clk_o, 0);
    check("pend.rst.running", running, 0);
    check("pend.rst.cfg_err", cfg_err, 0);
    check("pend.rst.cur_div", cur_div, 8'd3);
    #1 rst_n = 1'b1;
    cycle();
    check_all("pend.post", 1, 1, 1, 1, 0, 8'd3);
    cycle();
    check_all("pend.post1", 0, 0, 1, 1, 0, 8'd3);
    cycle();
    check_all("pend.post2", 0, 0, 1, 1, 0, 8'd3);
    cycle();
    check_all("pend.post3", 1, 1, 1, 1, 0, 8'd3);

    // N=2 written on the same edge en rises.
    do_reset();
    drive(1, 1, 8'd2); cycle();
    check_all("n2.c0", 1, 1, 1, 1, 0, 8'd2);
    drive(1, 0, 0); cycle();
    check_all("n2.c1", 0, 0, 1, 1, 0, 8'd2);
    cycle();
    check_all("n2.c2", 1, 1, 1, 1, 0, 8'd2);
    cycle();
    check_all("n2.c3", 0, 0, 1, 1, 0, 8'd2);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    check_all("rnd.reset", m_tick, m_clko, m_run, !m_pend_v, m_err, 8'(m_cur));
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if (!(cfg_valid && m_pend_v)) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_div   = 8'($urandom_range(0, 7));
      end
      @(posedge clk);
      m_step(en, cfg_valid, int'(cfg_div));
      #1;
      check_all($sformatf("rnd%0d", i), m_tick, m_clko, m_run, !m_pend_v, m_err, 8'(m_cur));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
